// File: rtl/snoop_bus_arbiter_if.sv
// snoop_bus_arbiter_if: requester and memory side signals of the snoop bus arbiter.
interface snoop_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_word;
    logic [3:0]         mem_q;
    logic [7:0]         bus;
    logic [N_REQ-1:0]   grant;
    logic [N_REQ-1:0]   ack;
    logic [3:0]         rdata;
    logic               err;
    modport master (output req, req_word, mem_q, input bus, grant, ack, rdata, err);
    modport slave  (input req, req_word, mem_q, output bus, grant, ack, rdata, err);
endinterface

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin owner of the shared snoop bus, one RM/WB transaction at a time.
// Defining SNOOP_ARB_STATS_EN adds saturating rm_count_o/wb_count_o transaction counters.
module snoop_bus_arbiter #(
    parameter int         N_REQ    = 4,
    parameter logic [1:0] RM       = 2'b01,
    parameter logic [1:0] WB       = 2'b10,
    parameter logic [1:0] IDLE_CMD = 2'b00
) (
    input  logic clk,
    input  logic rst,
`ifdef SNOOP_ARB_STATS_EN
    output logic [7:0] rm_count_o,
    output logic [7:0] wb_count_o,
`endif
    snoop_bus_arbiter_if.slave sb
);
    localparam int PW = $clog2(N_REQ);
    localparam logic [7:0] IDLE_WORD = {IDLE_CMD, 6'b0};
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_ACK} state_t;
    state_t           state_q, state_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [7:0]       bus_q, bus_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [3:0]       rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [PW-1:0]    idx, win;
    logic             found;
    logic [7:0]       win_word;
    logic             is_rm, is_wb;
    assign win_word = sb.req_word[8*win +: 8];
    assign is_rm    = cmd_q == RM;
    assign is_wb    = cmd_q == WB;
    // Search upward from the last owner so it gets lowest priority next round.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % N_REQ);
            if (!found && sb.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        bus_d   = IDLE_WORD;
        grant_d = grant_q;
        ack_d   = '0;
        ptr_d   = ptr_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_DRIVE;
                    cmd_d   = win_word[7:6];
                    grant_d = N_REQ'(1) << win;
                    ptr_d   = win;
                    bus_d   = (win_word[7:6] == RM || win_word[7:6] == WB) ? win_word : IDLE_WORD;
                end
            end
            S_DRIVE: begin
                state_d = S_ACK;
                ack_d   = grant_q;
                err_d   = !(is_rm || is_wb);
                rdata_d = is_rm ? sb.mem_q : rdata_q;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= IDLE_CMD;
            bus_q   <= IDLE_WORD;
            grant_q <= '0;
            ack_q   <= '0;
            ptr_q   <= PW'(N_REQ - 1);
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            bus_q   <= bus_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            ptr_q   <= ptr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
    assign sb.bus   = bus_q;
    assign sb.grant = grant_q;
    assign sb.ack   = ack_q;
    assign sb.rdata = rdata_q;
    assign sb.err   = err_q;
`ifdef SNOOP_ARB_STATS_EN
    logic [7:0] rm_cnt_q, rm_cnt_d, wb_cnt_q, wb_cnt_d;
    // Counted on the DRIVE->ACK edge; invalid commands never increment.
    always_comb begin
        rm_cnt_d = rm_cnt_q;
        wb_cnt_d = wb_cnt_q;
        if (state_q == S_DRIVE && is_rm && rm_cnt_q != 8'hFF) rm_cnt_d = rm_cnt_q + 8'd1;
        if (state_q == S_DRIVE && is_wb && wb_cnt_q != 8'hFF) wb_cnt_d = wb_cnt_q + 8'd1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rm_cnt_q <= '0;
            wb_cnt_q <= '0;
        end else begin
            rm_cnt_q <= rm_cnt_d;
            wb_cnt_q <= wb_cnt_d;
        end
    end
    assign rm_count_o = rm_cnt_q;
    assign wb_count_o = wb_cnt_q;
`endif
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter: vector table, directed corner sequences and randomized run against a transaction model.
module tb_snoop_bus_arbiter;
    localparam int N = 4;
    localparam logic [1:0] RM = 2'b01;
    localparam logic [1:0] WB = 2'b10;
    typedef struct {
        logic           rst;
        logic [N-1:0]   req;
        logic [8*N-1:0] words;
        logic [7:0]     bus;
        logic [N-1:0]   grant;
        logic [N-1:0]   ack;
        logic [3:0]     rdata;
        logic           err;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] mem [4];
    int checks = 0;
    int failures = 0;
    vec_t vt [$];
    int m_ptr, m_age, m_own, m_rm, m_wb;
    bit m_busy;
    logic [7:0] m_word;
    logic [3:0] m_mem [4];
    logic [7:0] e_bus;
    logic [N-1:0] e_grant, e_ack;
    logic [3:0] e_rdata;
    logic e_err;
    int waits [N];
    bit pend [N];
    int got, last, n;
`ifdef SNOOP_ARB_STATS_EN
    logic [7:0] rm_count, wb_count;
`endif
    always #5 clk = ~clk;
    snoop_bus_arbiter_if #(.N_REQ(N)) sb ();
    snoop_bus_arbiter #(.N_REQ(N)) dut (
        .clk(clk),
        .rst(rst),
`ifdef SNOOP_ARB_STATS_EN
        .rm_count_o(rm_count),
        .wb_count_o(wb_count),
`endif
        .sb(sb)
    );
    // Memory: reloads its preload on reset, writes on every WB word seen on the bus.
    assign sb.mem_q = mem[sb.bus[5:4]];
    always @(posedge clk) begin
        if (rst) begin
            mem[0] <= 4'h3;
            mem[1] <= 4'h0;
            mem[2] <= 4'hA;
            mem[3] <= 4'h0;
        end else if (sb.bus[7:6] == WB) begin
            mem[sb.bus[5:4]] <= sb.bus[3:0];
        end
    end
    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction
    function automatic logic [20:0] dut_out();
        return {sb.bus, sb.grant, sb.ack, sb.rdata, sb.err};
    endfunction
    function automatic void row(input logic r, input logic [N-1:0] q, input logic [8*N-1:0] w,
                                input logic [7:0] b, input logic [N-1:0] g, input logic [N-1:0] a,
                                input logic [3:0] d, input logic e);
        vec_t x;
        x.rst = r; x.req = q; x.words = w; x.bus = b; x.grant = g; x.ack = a; x.rdata = d; x.err = e;
        vt.push_back(x);
    endfunction
    function automatic logic [7:0] rand_word();
        int r;
        logic [1:0] c;
        r = $urandom_range(7);
        c = (r < 3) ? RM : (r < 6) ? WB : (r == 6) ? 2'b00 : 2'b11;
        return {c, 2'($urandom_range(3)), 4'($urandom_range(15))};
    endfunction
    function automatic void m_reset();
        m_ptr = N - 1; m_busy = 0; m_age = 0; m_own = 0; m_word = '0; m_rm = 0; m_wb = 0;
        e_bus = '0; e_grant = '0; e_ack = '0; e_rdata = '0; e_err = 1'b0;
        m_mem[0] = 4'h3; m_mem[1] = 4'h0; m_mem[2] = 4'hA; m_mem[3] = 4'h0;
        for (int i = 0; i < N; i++) begin
            waits[i] = 0;
            pend[i] = 0;
        end
    endfunction
    // Transaction model: expected outputs after the coming rising edge.
    function automatic void m_step();
        logic [1:0] c;
        if (rst) begin
            m_reset();
            return;
        end
        c = m_word[7:6];
        if (!m_busy) begin
            e_bus = '0; e_grant = '0; e_ack = '0; e_err = 1'b0;
            for (int k = 1; k <= N; k++)
                if (!m_busy && sb.req[(m_ptr + k) % N]) begin
                    m_own = (m_ptr + k) % N;
                    m_busy = 1;
                    m_age = 1;
                end
            if (m_busy) begin
                m_word = sb.req_word[8*m_own +: 8];
                m_ptr = m_own;
                e_grant[m_own] = 1'b1;
                e_bus = (m_word[7:6] == RM || m_word[7:6] == WB) ? m_word : 8'h00;
                for (int i = 0; i < N; i++)
                    if (i == m_own) begin
                        check($sformatf("fair_wait%0d", i), 64'(waits[i] <= N - 1), 64'd1);
                        waits[i] = 0;
                    end else if (sb.req[i]) waits[i]++;
            end
        end else if (m_age == 1) begin
            m_age = 2;
            e_bus = '0;
            e_ack = e_grant;
            e_err = !(c == RM || c == WB);
            if (c == RM) begin
                e_rdata = m_mem[m_word[5:4]];
                m_rm = (m_rm == 255) ? 255 : m_rm + 1;
            end
            if (c == WB) begin
                m_mem[m_word[5:4]] = m_word[3:0];
                m_wb = (m_wb == 255) ? 255 : m_wb + 1;
            end
        end else begin
            m_busy = 0; e_grant = '0; e_ack = '0; e_err = 1'b0;
        end
    endfunction
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sb.req = '0;
        sb.req_word = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic wait_ack(input string name);
        int c;
        c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while (sb.ack == '0 && c < 12);
        check({name, "_timeout"}, 64'(sb.ack != '0), 64'd1);
    endtask
    initial begin
        sb.req = '0;
        sb.req_word = '0;
        row(1, 4'b0000, 32'h0, 8'h00, 4'b0000, 4'b0000, 4'h0, 0);
        for (int i = 0; i < 5; i++) row(0, 4'b0000, 32'h0, 8'h00, 4'b0000, 4'b0000, 4'h0, 0);
        row(0, 4'b0010, 32'h0000_6000, 8'h60, 4'b0010, 4'b0000, 4'h0, 0);
        row(0, 4'b0010, 32'h0000_6000, 8'h00, 4'b0010, 4'b0010, 4'hA, 0);
        row(0, 4'b0000, 32'h0,         8'h00, 4'b0000, 4'b0000, 4'hA, 0);
        row(0, 4'b1000, 32'h9500_0000, 8'h95, 4'b1000, 4'b0000, 4'hA, 0);
        row(0, 4'b1000, 32'h9500_0000, 8'h00, 4'b1000, 4'b1000, 4'hA, 0);
        row(0, 4'b0001, 32'h0000_0050, 8'h00, 4'b0000, 4'b0000, 4'hA, 0);
        row(0, 4'b0001, 32'h0000_0050, 8'h50, 4'b0001, 4'b0000, 4'hA, 0);
        row(0, 4'b0001, 32'h0000_0050, 8'h00, 4'b0001, 4'b0001, 4'h5, 0);
        row(0, 4'b0000, 32'h0,         8'h00, 4'b0000, 4'b0000, 4'h5, 0);
        row(0, 4'b0100, 32'h00C7_0000, 8'h00, 4'b0100, 4'b0000, 4'h5, 0);
        row(0, 4'b0100, 32'h00C7_0000, 8'h00, 4'b0100, 4'b0100, 4'h5, 1);
        row(0, 4'b0000, 32'h0,         8'h00, 4'b0000, 4'b0000, 4'h5, 0);
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            rst = vt[i].rst;
            sb.req = vt[i].req;
            sb.req_word = vt[i].words;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), 64'(dut_out()),
                  64'({vt[i].bus, vt[i].grant, vt[i].ack, vt[i].rdata, vt[i].err}));
        end
        check("mem_tag0_untouched", 64'(mem[0]), 64'h3);
        check("mem_tag1_written", 64'(mem[1]), 64'h5);
        // All four requesting: strict rotation, one ack every 3 cycles.
        do_reset();
        sb.req = 4'b1111;
        for (int i = 0; i < N; i++) sb.req_word[8*i +: 8] = {RM, 2'(i), 4'h0};
        got = 0;
        last = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(posedge clk);
            #1;
            check("grant_onehot", 64'($onehot0(sb.grant)), 64'd1);
            if (sb.ack != '0) begin
                check($sformatf("rr_order%0d", got), 64'(sb.ack), 64'(4'b0001 << (got % 4)));
                if (got > 0) check("ack_spacing", 64'(c - last), 64'd3);
                last = c;
                sb.req = sb.req & ~sb.ack;
                if (got == 3) sb.req = 4'b0111;
                got++;
            end
        end
        check("rr_done", 64'(got), 64'd5);
        sb.req = '0;
        // Reset during DRIVE of an RM aborts it and restores the pointer.
        do_reset();
        sb.req = 4'b1000;
        sb.req_word = 32'h4000_0000;
        @(posedge clk);
        #1;
        check("t6_drive_bus", 64'(sb.bus), 64'h40);
        @(negedge clk);
        rst = 1'b1;
        sb.req = 4'b1100;
        sb.req_word = 32'h40BC_0000;
        @(posedge clk);
        #1;
        check("t6_reset_outs", 64'(dut_out()), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_ack("t6_first");
        check("t6_first_ack", 64'(sb.ack), 64'(4'b0100));
        sb.req = 4'b1000;
        wait_ack("t6_second");
        check("t6_second_ack", 64'(sb.ack), 64'(4'b1000));
        check("t6_second_rdata", 64'(sb.rdata), 64'h3);
        sb.req = '0;
        // Randomized requesters against the transaction model.
        @(negedge clk);
        rst = 1'b1;
        sb.req = '0;
        sb.req_word = '0;
        m_step();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            check($sformatf("rand_outs@%0d", cyc), 64'(dut_out()), 64'({e_bus, e_grant, e_ack, e_rdata, e_err}));
`ifdef SNOOP_ARB_STATS_EN
            check("rand_rm_count", 64'(rm_count), 64'(m_rm));
            check("rand_wb_count", 64'(wb_count), 64'(m_wb));
`endif
            rst = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (e_ack[i]) pend[i] = 0;
                else if (!pend[i] && $urandom_range(3) == 0) begin
                    pend[i] = 1;
                    sb.req_word[8*i +: 8] = rand_word();
                end
                sb.req[i] = pend[i];
            end
            m_step();
        end
`ifdef SNOOP_ARB_STATS_EN
        do_reset();
        sb.req = 4'b0001;
        sb.req_word = 32'h0000_0091;
        n = 0;
        for (int c = 0; c < 1000 && n < 300; c++) begin
            @(posedge clk);
            #1;
            if (sb.ack[0]) n++;
        end
        check("wb300_acks", 64'(n), 64'd300);
        check("wb_count_sat", 64'(wb_count), 64'hFF);
        check("rm_count_zero", 64'(rm_count), 64'h0);
        sb.req = '0;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
